// File: rtl/instr_sequencer_if.sv
// Bus between the instruction sequencer and its machine-cycle controller / decoder.
// The master modport drives the M-cycle inputs, and the slave modport (the sequencer) drives the status outputs.
interface instr_sequencer_if;
  // Handshake: MC_EN qualifies every input on the CLK edge where it is high.
  // OPCODE is captured only when OPCODE_VALID=1 in the fetch state.
  // LAST_CYCLE is sampled only in the execute state.
  // INT_REQ is sampled only at an instruction boundary.
  // All outputs reflect registered state and are valid throughout the cycle.
  logic        MC_EN;
  logic [7:0]  OPCODE;
  logic        OPCODE_VALID;
  logic        LAST_CYCLE;
  logic        INT_REQ;
  logic        FETCH;
  logic [7:0]  IR;
  logic [2:0]  MCYC;
  logic        CB;
  logic        INT_DISP;
  logic        SEQ_ERR;
  logic [25:0] a;
  logic [1:0]  dbg_state;

  modport master (
    output MC_EN, OPCODE, OPCODE_VALID, LAST_CYCLE, INT_REQ,
    input  FETCH, IR, MCYC, CB, INT_DISP, SEQ_ERR, a, dbg_state
  );

  modport slave (
    input  MC_EN, OPCODE, OPCODE_VALID, LAST_CYCLE, INT_REQ,
    output FETCH, IR, MCYC, CB, INT_DISP, SEQ_ERR, a, dbg_state
  );
endinterface

// File: rtl/instr_sequencer.sv
// Instruction sequencer: fetch/execute/interrupt-dispatch FSM feeding the Decoder1 a[] vector.
// Define SEQ_CB_PREFIX_EN to compile in the 0xCB prefix page; without it, CB is tied to 0.
module instr_sequencer (
    input  logic CLK,
    input  logic nRESET,
    instr_sequencer_if.slave bus
);

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_EXEC  = 2'd1,
        S_INT   = 2'd2
    } state_t;

    localparam logic [7:0] PREFIX_CB = 8'hCB;
    localparam logic [2:0] INT_LAST  = 3'd4;

    state_t     state;
    logic [7:0] ir_q;
    logic [2:0] mcyc_q;
    logic       cb_q;
    logic       seq_err_q;

`ifndef SEQ_CB_PREFIX_EN
    assign cb_q = 1'b0;
`endif

    always_ff @(posedge CLK or negedge nRESET) begin
        if (!nRESET) begin
            state     <= S_FETCH;
            ir_q      <= 8'h00;
            mcyc_q    <= 3'd0;
            seq_err_q <= 1'b0;
`ifdef SEQ_CB_PREFIX_EN
            cb_q      <= 1'b0;
`endif
        end else if (bus.MC_EN) begin
            case (state)
                S_FETCH: begin
                    if (bus.OPCODE_VALID) begin
                        ir_q   <= bus.OPCODE;
                        mcyc_q <= 3'd0;
                        state  <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    if (!bus.LAST_CYCLE) begin
                        // An instruction that outruns 8 M-cycles pins MCYC at 7 and flags it.
                        if (mcyc_q == 3'd7) begin
                            seq_err_q <= 1'b1;
                        end else begin
                            mcyc_q <= mcyc_q + 3'd1;
                        end
                    end else begin
                        mcyc_q <= 3'd0;
`ifdef SEQ_CB_PREFIX_EN
                        // The prefix must reach its opcode without an interrupt in between.
                        if (ir_q == PREFIX_CB && !cb_q) begin
                            cb_q  <= 1'b1;
                            state <= S_FETCH;
                        end else if (bus.INT_REQ) begin
                            cb_q  <= 1'b0;
                            state <= S_INT;
                        end else begin
                            cb_q  <= 1'b0;
                            state <= S_FETCH;
                        end
`else
                        if (bus.INT_REQ) begin
                            state <= S_INT;
                        end else begin
                            state <= S_FETCH;
                        end
`endif
                    end
                end
                S_INT: begin
                    if (mcyc_q == INT_LAST) begin
                        mcyc_q <= 3'd0;
                        state  <= S_FETCH;
                    end else begin
                        mcyc_q <= mcyc_q + 3'd1;
                    end
                end
                default: begin
                    mcyc_q <= 3'd0;
                    state  <= S_FETCH;
                end
            endcase
        end
    end

`ifndef SEQ_CB_PREFIX_EN
    // Keeps the prefix constant referenced in builds without the CB page.
    logic unused_prefix;
    assign unused_prefix = ^PREFIX_CB;
`endif

    assign bus.FETCH     = (state == S_FETCH);
    assign bus.INT_DISP  = (state == S_INT);
    assign bus.IR        = ir_q;
    assign bus.MCYC      = mcyc_q;
    assign bus.CB        = cb_q;
    assign bus.SEQ_ERR   = seq_err_q;
    assign bus.dbg_state = state;

    // Decoder1 wants true/complement pairs; the MCYC pairs put the true bit on the even index.
    always_comb begin
        bus.a     = '0;
        bus.a[1]  = cb_q;
        bus.a[0]  = ~cb_q;
        bus.a[3]  = (state == S_INT);
        bus.a[2]  = (state != S_INT);
        for (int i = 0; i < 8; i++) begin
            bus.a[5 + 2*i] = ir_q[7 - i];
            bus.a[4 + 2*i] = ~ir_q[7 - i];
        end
        bus.a[20] = mcyc_q[0];
        bus.a[21] = ~mcyc_q[0];
        bus.a[22] = mcyc_q[1];
        bus.a[23] = ~mcyc_q[1];
        bus.a[24] = mcyc_q[2];
        bus.a[25] = ~mcyc_q[2];
    end

endmodule

// File: tb/tb_instr_sequencer.sv
// Directed bench for instr_sequencer: the driver pushes hand-written expected snapshots into a queue,
// and a negedge monitor pops one snapshot after each clock edge and compares it with the outputs.
module tb_instr_sequencer;

  localparam int SW = 41;
  localparam logic [1:0] M_FETCH = 2'd0;
  localparam logic [1:0] M_EXEC  = 2'd1;
  localparam logic [1:0] M_INT   = 2'd2;

  logic CLK;
  logic nRESET;
  instr_sequencer_if bus();

  instr_sequencer dut (
    .CLK    (CLK),
    .nRESET (nRESET),
    .bus    (bus)
  );

  int checks;
  int errors;
  int step_no;
  logic [SW-1:0] exp_q[$];

  // clock / reset
  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout required completion");
    $fatal(1, "watchdog");
  end

  // Decoder1 mapping written out from the pin list.
  function automatic logic [25:0] build_a(input logic cb, input logic intd,
                                          input logic [7:0] ir, input logic [2:0] mc);
    logic [25:0] v;
    v = '0;
    v[1] = cb;   v[0] = ~cb;
    v[3] = intd; v[2] = ~intd;
    for (int i = 0; i < 8; i++) begin
      v[5 + 2*i] = ir[7 - i];
      v[4 + 2*i] = ~ir[7 - i];
    end
    v[20] = mc[0]; v[21] = ~mc[0];
    v[22] = mc[1]; v[23] = ~mc[1];
    v[24] = mc[2]; v[25] = ~mc[2];
    return v;
  endfunction

  function automatic logic [SW-1:0] mk(input logic [1:0] mode, input logic [7:0] ir,
                                       input logic [2:0] mc, input logic cb, input logic err);
    logic f;
    logic d;
    f = (mode == M_FETCH);
    d = (mode == M_INT);
    return {f, d, cb, err, mc, ir, build_a(cb, d, ir, mc)};
  endfunction

  function automatic logic [SW-1:0] snap();
    return {bus.FETCH, bus.INT_DISP, bus.CB, bus.SEQ_ERR, bus.MCYC, bus.IR, bus.a};
  endfunction

  task automatic chk(input string name, input logic [SW-1:0] got, input logic [SW-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h required %h", name, got, exp);
    end
  endtask

  // driver: apply one M-cycle, then queue the state expected after the edge
  task automatic step(input logic en, input logic [7:0] opc, input logic vld,
                      input logic lst, input logic irq,
                      input logic [1:0] e_mode, input logic [7:0] e_ir,
                      input logic [2:0] e_mc, input logic e_cb, input logic e_err);
    bus.MC_EN        = en;
    bus.OPCODE       = opc;
    bus.OPCODE_VALID = vld;
    bus.LAST_CYCLE   = lst;
    bus.INT_REQ      = irq;
    @(posedge CLK);
    exp_q.push_back(mk(e_mode, e_ir, e_mc, e_cb, e_err));
    #1;
  endtask

  // monitor / scoreboard
  always @(negedge CLK) begin
    if (exp_q.size() > 0) begin
      logic [SW-1:0] e;
      logic [SW-1:0] g;
      e = exp_q.pop_front();
      g = snap();
      step_no++;
      checks++;
      if (g !== e) begin
        errors++;
        $display("FAIL step%0d: got fetch=%b int=%b cb=%b err=%b mcyc=%0d ir=%h a=%h required fetch=%b int=%b cb=%b err=%b mcyc=%0d ir=%h a=%h",
                 step_no, g[40], g[39], g[38], g[37], g[36:34], g[33:26], g[25:0],
                 e[40], e[39], e[38], e[37], e[36:34], e[33:26], e[25:0]);
      end
    end
  end

  initial begin
    logic [25:0] a_rst;
    checks = 0;
    errors = 0;
    step_no = 0;
    nRESET = 1'b0;
    bus.MC_EN = 1'b0;
    bus.OPCODE = 8'h00;
    bus.OPCODE_VALID = 1'b0;
    bus.LAST_CYCLE = 1'b0;
    bus.INT_REQ = 1'b0;
    #23;
    a_rst = 26'h2A55555;
    chk("reset_state", snap(), mk(M_FETCH, 8'h00, 3'd0, 1'b0, 1'b0));
    chk("reset_a_literal", {15'd0, bus.a}, {15'd0, a_rst});
    @(negedge CLK);
    nRESET = 1'b1;
    #1;

    // first fetch: 0x3E
    step(1, 8'h3E, 1, 0, 0, M_EXEC, 8'h3E, 3'd0, 0, 0);
    // execute: one more cycle, then last
    step(1, 8'h00, 0, 0, 0, M_EXEC, 8'h3E, 3'd1, 0, 0);
    step(1, 8'h00, 0, 1, 0, M_FETCH, 8'h3E, 3'd0, 0, 0);
    // fetch with no valid opcode holds
    step(1, 8'h99, 0, 1, 1, M_FETCH, 8'h3E, 3'd0, 0, 0);

    // MC_EN low stalls everything mid-instruction
    step(1, 8'h12, 1, 0, 0, M_EXEC, 8'h12, 3'd0, 0, 0);
    step(1, 8'h00, 0, 0, 0, M_EXEC, 8'h12, 3'd1, 0, 0);
    for (int i = 0; i < 3; i++) step(0, 8'hFF, 1, 1, 1, M_EXEC, 8'h12, 3'd1, 0, 0);
    step(1, 8'h00, 0, 1, 0, M_FETCH, 8'h12, 3'd0, 0, 0);

    // interrupt dispatch after opcode 0x00: 5 M-cycles, inputs ignored
    step(1, 8'h00, 1, 0, 0, M_EXEC, 8'h00, 3'd0, 0, 0);
    step(1, 8'h00, 0, 1, 1, M_INT, 8'h00, 3'd0, 0, 0);
    for (int i = 1; i < 5; i++) step(1, 8'hAA, 1, 1, 1, M_INT, 8'h00, 3'(i), 0, 0);
    step(1, 8'hAA, 1, 1, 1, M_FETCH, 8'h00, 3'd0, 0, 0);

    // 0xCB prefix
    step(1, 8'hCB, 1, 0, 0, M_EXEC, 8'hCB, 3'd0, 0, 0);
`ifdef SEQ_CB_PREFIX_EN
    step(1, 8'h00, 0, 1, 1, M_FETCH, 8'hCB, 3'd0, 1, 0);
    step(1, 8'h37, 1, 0, 1, M_EXEC, 8'h37, 3'd0, 1, 0);
    step(1, 8'h00, 0, 1, 0, M_FETCH, 8'h37, 3'd0, 0, 0);
    // CB page opcode 0xCB is ordinary: interrupt may follow it
    step(1, 8'hCB, 1, 0, 0, M_EXEC, 8'hCB, 3'd0, 0, 0);
    step(1, 8'h00, 0, 1, 0, M_FETCH, 8'hCB, 3'd0, 1, 0);
    step(1, 8'hCB, 1, 0, 0, M_EXEC, 8'hCB, 3'd0, 1, 0);
    step(1, 8'h00, 0, 1, 1, M_INT, 8'hCB, 3'd0, 0, 0);
`else
    step(1, 8'h00, 0, 1, 1, M_INT, 8'hCB, 3'd0, 0, 0);
`endif
    for (int i = 1; i < 5; i++) step(1, 8'h00, 0, 0, 0, M_INT, 8'hCB, 3'(i), 0, 0);
    step(1, 8'h00, 0, 0, 0, M_FETCH, 8'hCB, 3'd0, 0, 0);

    // MCYC saturation and sticky SEQ_ERR
    step(1, 8'h55, 1, 0, 0, M_EXEC, 8'h55, 3'd0, 0, 0);
    for (int i = 1; i < 8; i++) step(1, 8'h00, 0, 0, 0, M_EXEC, 8'h55, 3'(i), 0, 0);
    step(1, 8'h00, 0, 0, 0, M_EXEC, 8'h55, 3'd7, 0, 1);
    step(1, 8'h00, 0, 0, 0, M_EXEC, 8'h55, 3'd7, 0, 1);
    step(1, 8'h00, 0, 1, 0, M_FETCH, 8'h55, 3'd0, 0, 1);

    // reset pulse in the middle of a dispatch
    step(1, 8'h00, 1, 0, 0, M_EXEC, 8'h00, 3'd0, 0, 1);
    step(1, 8'h00, 0, 1, 1, M_INT, 8'h00, 3'd0, 0, 1);
    step(1, 8'h00, 0, 0, 0, M_INT, 8'h00, 3'd1, 0, 1);
    @(negedge CLK);
    #1;
    nRESET = 1'b0;
    #1;
    chk("async_reset_mid_int", snap(), mk(M_FETCH, 8'h00, 3'd0, 0, 0));
    bus.MC_EN = 1'b1;
    bus.OPCODE = 8'h66;
    bus.OPCODE_VALID = 1'b1;
    @(posedge CLK);
    #1;
    chk("reset_held_over_edge", snap(), mk(M_FETCH, 8'h00, 3'd0, 0, 0));
    @(negedge CLK);
    nRESET = 1'b1;
    #1;
    step(1, 8'h77, 1, 1, 1, M_EXEC, 8'h77, 3'd0, 0, 0);

    @(negedge CLK);
    #1;
    chk("queue_drained", SW'(exp_q.size()), SW'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
